// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the default bit period.
// Used by both the transmit and receive directions.
package uart_pkg;

    // Two-bit FSM state; encodings are fixed so both directions agree.
    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'b00;
    localparam uart_state_t ST_START = 2'b01;
    localparam uart_state_t ST_DATA  = 2'b10;
    localparam uart_state_t ST_STOP  = 2'b11;

    // Enabled clock cycles per serial bit (e.g. 125 MHz / 115200 baud).
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 1085;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter. Counts enabled cycles while the FSM is running and
// raises bit_end on the last enabled cycle of each serial bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic run,
    output logic bit_end
);

    // Compare value held at full counter width so no legal period wraps.
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] count;

    // Strobe only on an enabled edge, so a stalled enable never ends a bit.
    assign bit_end = en && run && (count == LAST);

    // Count enabled cycles within a bit; park at zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'd0;
        end else if (en) begin
            if (!run || (count == LAST)) begin
                count <= 16'd0;
            end else begin
                count <= count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1, MSB first, one-byte holding register in front of
// the shift register so a second byte can follow with no idle gap.
//
// Write handshake: a byte is taken on an edge where txclken && wr_en &&
// ready; ready is simply "holding register empty". A write while ready is
// low is dropped, not stalled -- the writer must watch ready.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic        txclk,
    input  logic        rst_n,
    input  logic        txclken,
    input  logic [7:0]  din,
    input  logic        wr_en,
    output logic        ready,
    output logic        busy,
    output logic        tx_done,
    output logic        tx,
    output uart_state_t fsm_state
);

    uart_state_t state;
    logic [7:0]  hold;
    logic        hold_valid;
    logic [7:0]  shift;
    logic [2:0]  bitpos;
    logic        tx_done_q;
    logic        bit_end;
    logic        write_accept;
    logic        frame_slot;
    logic        load;
    logic [7:0]  next_byte;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (txclk),
        .rst_n  (rst_n),
        .en     (txclken),
        .run    (state != ST_IDLE),
        .bit_end(bit_end)
    );

    assign write_accept = txclken && wr_en && !hold_valid;
    // The shifter can take a new byte when idle or as a stop bit finishes.
    assign frame_slot   = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);
    assign load         = txclken && frame_slot && (hold_valid || write_accept);
    // A queued byte always goes first; din only bypasses an empty holder.
    assign next_byte    = hold_valid ? hold : din;

    assign ready     = !hold_valid;
    assign busy      = (state != ST_IDLE);
    assign tx_done   = tx_done_q && txclken;
    assign fsm_state = state;

    // Holding register: filled by accepted writes unless they go straight to the shifter.
    always_ff @(posedge txclk or negedge rst_n) begin
        if (!rst_n) begin
            hold       <= 8'd0;
            hold_valid <= 1'b0;
        end else if (load) begin
            hold_valid <= 1'b0;
        end else if (write_accept) begin
            hold       <= din;
            hold_valid <= 1'b1;
        end
    end

    // Frame sequencing: start bit, eight data bits MSB first, stop bit.
    always_ff @(posedge txclk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            shift  <= 8'd0;
            bitpos <= 3'd0;
        end else if (txclken) begin
            case (state)
                ST_IDLE: begin
                    bitpos <= 3'd0;
                    if (load) begin
                        shift <= next_byte;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift <= {shift[6:0], 1'b0};
                        if (bitpos == 3'd7) begin
                            bitpos <= 3'd0;
                            state  <= ST_STOP;
                        end else begin
                            bitpos <= bitpos + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (load) begin
                            shift <= next_byte;
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    bitpos <= 3'd0;
                end
            endcase
        end
    end

    // Serial line registered from the current state, one enabled cycle behind it.
    always_ff @(posedge txclk or negedge rst_n) begin
        if (!rst_n) begin
            tx <= 1'b1;
        end else if (txclken) begin
            case (state)
                ST_START: tx <= 1'b0;
                ST_DATA:  tx <= shift[7];
                default:  tx <= 1'b1;
            endcase
        end
    end

    // Completion flag lines up with the final stop-bit cycle on tx.
    always_ff @(posedge txclk or negedge rst_n) begin
        if (!rst_n) begin
            tx_done_q <= 1'b0;
        end else if (txclken) begin
            tx_done_q <= bit_end && (state == ST_STOP);
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a queue-based line model predicts tx, ready,
// busy and tx_done each cycle, and a behavioural receiver decodes the line
// against a scoreboard of accepted bytes.
module tb_uart_transmitter;

    localparam int C = 4;

    logic       txclk = 1'b0;
    logic       rst_n;
    logic       txclken;
    logic [7:0] din;
    logic       wr_en;
    logic       ready;
    logic       busy;
    logic       tx_done;
    logic       tx;
    logic [1:0] fsm_state;

    uart_transmitter #(.CLKS_PER_BIT(C)) dut (
        .txclk    (txclk),
        .rst_n    (rst_n),
        .txclken  (txclken),
        .din      (din),
        .wr_en    (wr_en),
        .ready    (ready),
        .busy     (busy),
        .tx_done  (tx_done),
        .tx       (tx),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 txclk = ~txclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- counters and model state ----------------
    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    // Line model: one entry per upcoming enabled cycle of tx.
    logic       line_q[$];
    logic       end_q[$];
    logic       m_tx = 1'b1;
    logic       m_done = 1'b0;
    logic       m_hold_v = 1'b0;
    logic [7:0] m_hold = 8'd0;

    // Scoreboard of accepted bytes, consumed by the line receiver.
    logic [7:0] exp_q[$];
    logic       rx_active = 1'b0;
    int         rx_idx = 0;
    logic [7:0] rx_byte = 8'd0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // line[9] is sent first
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b0, b, 1'b1};
        for (int i = 9; i >= 0; i--) begin
            for (int r = 0; r < C; r++) begin
                line_q.push_back(f[i]);
                end_q.push_back((i == 0) && (r == C - 1));
            end
        end
    endtask

    task automatic model_reset();
        line_q.delete();
        end_q.delete();
        exp_q.delete();
        m_tx      = 1'b1;
        m_done    = 1'b0;
        m_hold_v  = 1'b0;
        rx_active = 1'b0;
    endtask

    // One enabled edge: emit the next line bit, then refill the line if it ran dry.
    task automatic model_edge(input logic wr, input logic [7:0] d);
        logic accept;
        accept = wr && !m_hold_v;
        if (line_q.size() > 0) begin
            m_tx   = line_q.pop_front();
            m_done = end_q.pop_front();
        end else begin
            m_tx   = 1'b1;
            m_done = 1'b0;
        end
        if ((line_q.size() == 0) && m_hold_v) begin
            push_frame(m_hold);
            m_hold_v = 1'b0;
        end else if ((line_q.size() == 0) && accept) begin
            push_frame(d);
        end else if (accept) begin
            m_hold   = d;
            m_hold_v = 1'b1;
        end
        if (accept) exp_q.push_back(d);
    endtask

    // Receiver: resync on a falling edge, sample each bit at its middle.
    task automatic rx_feed(input logic s);
        if (!rx_active) begin
            if (s == 1'b0) begin
                rx_active = 1'b1;
                rx_idx    = 0;
            end
        end else begin
            rx_idx++;
            if ((rx_idx % C == C / 2) && (rx_idx / C >= 1) && (rx_idx / C <= 8)) begin
                rx_byte = {rx_byte[6:0], s};
            end else if (rx_idx == 9 * C + C / 2) begin
                chk("rx_stop_bit", s, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_byte: got %0h expected no byte at %0t", rx_byte, $time);
                end else begin
                    chk("rx_byte", rx_byte, exp_q.pop_front());
                end
                rx_active = 1'b0;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic en, input logic wr, input logic [7:0] d);
        txclken = en;
        wr_en   = wr;
        din     = d;
        @(posedge txclk);
        if (en) model_edge(wr, d);
        #1;
        chk("tx", tx, m_tx);
        chk("ready", ready, !m_hold_v);
        chk("busy", busy, line_q.size() != 0);
        chk("tx_done", tx_done, m_done && en);
        if (tx_done === 1'b1) done_seen++;
        if (en) rx_feed(tx);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int low_clocks;
        logic seen_rise;
        int budget;

        vecs[0] = '{8'hA5, 10'b0101001011};
        vecs[1] = '{8'h00, 10'b0000000001};
        vecs[2] = '{8'hFF, 10'b0111111111};
        vecs[3] = '{8'h5A, 10'b0010110101};
        vecs[4] = '{8'h80, 10'b0100000001};
        vecs[5] = '{8'h3C, 10'b0001111001};

        rst_n   = 1'b0;
        txclken = 1'b0;
        wr_en   = 1'b0;
        din     = 8'h00;
        repeat (2) @(posedge txclk);
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_ready", ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_tx_done", tx_done, 0);
        chk("reset_state", fsm_state, 0);
        rst_n = 1'b1;
        idle(3);

        // Single frames from the vector table, timed against the write edge.
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, vecs[k].data);
            chk("latency_tx_still_idle", tx, 1);
            for (int c = 1; c <= 10 * C; c++) begin
                step(1'b1, 1'b0, 8'h00);
                chk("frame_tx", tx, vecs[k].line[9 - (c - 1) / C]);
                chk("frame_done", tx_done, c == 10 * C);
                if (c < 10 * C) chk("frame_busy", busy, 1);
            end
            idle(2);
        end

        // Back-to-back: second byte queued mid-frame follows with no gap.
        done_seen = 0;
        step(1'b1, 1'b1, 8'h3C);
        idle(10);
        step(1'b1, 1'b1, 8'hC3);
        chk("b2b_ready_low", ready, 0);
        for (int c = 12; c <= 20 * C; c++) begin
            step(1'b1, 1'b0, 8'h00);
            if (c < 10 * C) chk("b2b_ready", ready, 0);
            if ((c > 10 * C) && (c <= 11 * C)) chk("b2b_gapless_start", tx, 0);
        end
        idle(3);
        chk("b2b_done_pulses", done_seen, 2);

        // Overflow: third write in a row is dropped.
        step(1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b1, 8'h22);
        step(1'b1, 1'b1, 8'h33);
        chk("ovf_ready", ready, 0);
        idle(20 * C + 4);
        chk("ovf_scoreboard_empty", exp_q.size(), 0);

        // Enable every third clock: each bit spans 3*C clocks.
        low_clocks = 0;
        seen_rise  = 1'b0;
        step(1'b1, 1'b1, 8'h80);
        for (int i = 1; i <= 3 * 10 * C + 6; i++) begin
            step((i % 3) == 0, 1'b0, 8'h00);
            if ((tx == 1'b0) && !seen_rise) low_clocks++;
            if ((low_clocks > 0) && (tx == 1'b1)) seen_rise = 1'b1;
        end
        chk("gated_start_len", low_clocks, 3 * C);
        chk("gated_scoreboard_empty", exp_q.size(), 0);
        idle(2);

        // Reset during data bit 3 of 0xFF with 0x00 queued.
        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 8'h00);
        idle(16);
        chk("rst_pre_ready", ready, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async_tx", tx, 1);
        chk("rst_async_ready", ready, 1);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_tx_done", tx_done, 0);
        @(posedge txclk);
        #3;
        rst_n = 1'b1;
        idle(12 * C);

        // Random traffic with random enable gating.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)));
        end
        budget = 0;
        while (((line_q.size() != 0) || m_hold_v) && (budget < 30 * C)) begin
            step(1'b1, 1'b0, 8'h00);
            budget++;
        end
        if ((line_q.size() != 0) || m_hold_v) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending bits expected 0", line_q.size());
        end
        idle(2);
        chk("random_scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1085, gives the enabled clock cycles per serial bit; legal range 2..65535.
REQ-002 Ports: txclk input 1 -- the single clock; all state updates on its rising edge.
REQ-003 Ports: rst_n input 1 -- asynchronous, active-low reset.
REQ-004 Ports: txclken input 1 -- clock enable; state advances only on edges where txclken=1.
REQ-005 Ports: din input 8 -- byte to transmit.
REQ-006 Ports: wr_en input 1 -- write strobe for din.
REQ-007 Ports: ready output 1 -- holding register empty; combinational, equal to !hold_valid.
REQ-008 Ports: busy output 1 -- high whenever the state is not IDLE.
REQ-009 Ports: tx_done output 1 -- one-enabled-cycle pulse when a stop bit completes.
REQ-010 Ports: tx output 1 -- registered serial line, idle high.

Function
REQ-011 Frame format SHALL be: start bit 0, eight data bits MSB first (din[7] first), one stop bit 1, no parity; each bit lasts exactly CLKS_PER_BIT enabled cycles, so a frame is 10*CLKS_PER_BIT enabled cycles.
REQ-012 A write SHALL be accepted on an edge with txclken=1, wr_en=1 and ready=1; din is captured into the holding register and hold_valid is set.
REQ-013 A write with ready=0 or txclken=0 SHALL be ignored; the holding register is not modified.
REQ-014 State machine states: IDLE, START, DATA, STOP, held in a 2-bit register.
REQ-015 IDLE: tx=1, counter=0, bitpos=0; on an enabled edge with hold_valid=1, or with a write being accepted, the byte moves to the shift register, hold_valid clears, and state becomes START.
REQ-016 Latency: tx SHALL go low on the first enabled edge after the byte enters the shift register, i.e. one enabled cycle after write acceptance when idle with an empty holding register.
REQ-017 START: tx=0; 16-bit counter increments each enabled cycle; at CLKS_PER_BIT-1 the counter resets to 0 and state becomes DATA.
REQ-018 DATA: tx=shift[7]; at counter CLKS_PER_BIT-1 the counter resets, the shift register shifts left one place, and bitpos increments; after bitpos 7 completes, bitpos returns to 0 and state becomes STOP.
REQ-019 STOP: tx=1; at counter CLKS_PER_BIT-1, tx_done pulses, the counter resets, and the next state is chosen per REQ-020.
REQ-020 Stop-bit exit: if hold_valid=1 or a write is accepted on that same edge, the next byte loads and state goes directly to START with no idle gap; otherwise state goes to IDLE.
REQ-021 A write accepted during any state other than IDLE SHALL only fill the holding register; the frame in progress is unaffected and no more than one byte is queued.
REQ-022 When txclken=0, all registers and tx SHALL hold their values, and tx_done SHALL be 0.
REQ-023 Counter compare SHALL be done at 16-bit width, with no wrap for any legal CLKS_PER_BIT.
REQ-024 An illegal state encoding SHALL recover to IDLE with tx=1.

Reset
REQ-025 rst_n=0 SHALL asynchronously force: state=IDLE, tx=1, counter=0, bitpos=0, shift=0, hold_valid=0 (ready=1), busy=0, tx_done=0.
REQ-026 Reset mid-frame SHALL abort the frame immediately (tx returns high) and discard any queued byte; operation resumes on the first enabled edge after rst_n rises.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state type (IDLE/START/DATA/STOP, 2 bits, encodings 00/01/10/11) and the CLKS_PER_BIT default; both UART directions use it.
REQ-028 One sub-module, uart_baud_tick, SHALL contain the 16-bit bit-period counter and output a bit_end strobe; the FSM, holding register and shifter stay in uart_transmitter.

Verification (CLKS_PER_BIT=4, txclken=1 unless stated)
REQ-029 Single byte: write 0xA5 when idle -> tx shows 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; tx_done pulses once at cycle 40; busy=1 throughout the frame.
REQ-030 Back-to-back: write 0x3C, then 0xC3 during the first frame -> ready=0 until 0xC3 loads, then 0xC3's start bit immediately follows the stop bit, giving 80 contiguous cycles and two tx_done pulses.
REQ-031 Overflow: three writes 0x11, 0x22, 0x33 in consecutive cycles -> 0x11 is sent, 0x22 is queued, 0x33 is dropped (ready=0); line output is 0x11 then 0x22.
REQ-032 Enable gating: txclken=1 every 3rd cycle, send 0x80 -> each bit lasts 12 clocks, and the frame is bit-identical to the case with enable always high.
REQ-033 Reset mid-frame: assert rst_n=0 during DATA bit 3 of 0xFF with 0x00 queued -> tx=1 and ready=1 immediately; no further frame starts without a new write.
REQ-034 Loopback: connect tx to the existing UART receiver using the same CLKS_PER_BIT, send 0x00, 0xFF, 0x5A -> the receiver dout matches each byte.
